// File: rtl/ahb_subordinate_mem.sv
// ahb_subordinate_mem: AHB5 subordinate with word-addressed memory, programmable wait states and two-cycle ERROR
module ahb_subordinate_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic                    HSEL,
  input  logic [ADDR_WIDTH-1:0]   HADDR,
  input  logic [1:0]              HTRANS,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [DATA_WIDTH-1:0]   HWDATA,
  input  logic [DATA_WIDTH/8-1:0] HWSTRB,
  input  logic                    HREADY,
  output logic                    HREADYOUT,
  output logic                    HRESP,
  output logic [DATA_WIDTH-1:0]   HRDATA
);
  localparam int BW  = DATA_WIDTH / 8;
  localparam int OFF = $clog2(BW);
  localparam int XW  = ADDR_WIDTH - OFF;
  localparam int IW  = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t                r_state;
  logic                  r_hreadyout;
  logic                  r_hresp;
  logic [DATA_WIDTH-1:0] r_hrdata;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  logic [2:0]            r_size;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic                  w_open;
  logic                  w_accept;
  logic                  w_err;
  logic [OFF-1:0]        w_amask;
  logic [XW-1:0]         w_idx;
  logic [XW-1:0]         w_cur_idx;
  logic [XW-1:0]         w_rd_idx;
  logic [4:0]            w_nbytes;
  logic [BW-1:0]         w_lane;
  logic [BW-1:0]         w_mask;
  logic                  w_wr_now;
  logic                  w_fwd;
  logic [DATA_WIDTH-1:0] w_wr_word;
  logic [DATA_WIDTH-1:0] w_rd_data;

  assign w_open    = r_state == S_IDLE || r_state == S_DATA || r_state == S_ERR2;
  assign w_accept  = w_open && HSEL && HREADY && (HTRANS == 2'b10 || HTRANS == 2'b11);
  assign w_idx     = HADDR[ADDR_WIDTH-1:OFF];
  assign w_cur_idx = r_addr[ADDR_WIDTH-1:OFF];
  assign w_amask   = OFF'((8'd1 << HSIZE) - 8'd1);
  assign w_err     = (ADDR_WIDTH'(w_idx) >= ADDR_WIDTH'(MEM_DEPTH)) ||
                     (|(HADDR[OFF-1:0] & w_amask)) || (HSIZE > 3'(OFF));

  // byte lanes covered by the captured size/offset, then qualified by the data-phase strobes
  assign w_nbytes = 5'd1 << r_size;
  assign w_lane   = BW'((17'd1 << w_nbytes) - 17'd1) << r_addr[OFF-1:0];
  assign w_mask   = w_lane & HWSTRB;
  assign w_wr_now = r_state == S_DATA && r_write;

  always_comb begin
    w_wr_word = r_mem[w_cur_idx[IW-1:0]];
    for (int b = 0; b < BW; b++)
      if (w_mask[b]) w_wr_word[8*b +: 8] = HWDATA[8*b +: 8];
  end

  // a read accepted while a write to the same word completes sees the merged word
  assign w_rd_idx  = w_accept ? w_idx : w_cur_idx;
  assign w_fwd     = w_wr_now && w_rd_idx == w_cur_idx;
  assign w_rd_data = w_fwd ? w_wr_word : r_mem[w_rd_idx[IW-1:0]];

  always_ff @(posedge HCLK)
    if (w_wr_now && !HRESET && |w_mask) r_mem[w_cur_idx[IW-1:0]] <= w_wr_word;

  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET) begin
      r_state     <= S_IDLE;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
      r_hrdata    <= '0;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_size      <= '0;
    end else if (w_accept) begin
      r_addr      <= HADDR;
      r_write     <= HWRITE;
      r_size      <= HSIZE;
      r_state     <= w_err ? S_ERR1 : (WAIT_STATES > 0) ? S_WAIT : S_DATA;
      r_hreadyout <= !w_err && (WAIT_STATES == 0);
      r_hresp     <= w_err;
      r_cnt       <= 4'(WAIT_STATES);
      if (!w_err && (WAIT_STATES == 0) && !HWRITE) r_hrdata <= w_rd_data;
    end else begin
      r_state     <= r_state == S_WAIT ? (r_cnt == 4'd1 ? S_DATA : S_WAIT) :
                     r_state == S_ERR1 ? S_ERR2 : S_IDLE;
      r_hreadyout <= r_state != S_WAIT || r_cnt == 4'd1;
      r_hresp     <= r_state == S_ERR1;
      r_cnt       <= r_state == S_WAIT ? r_cnt - 4'd1 : r_cnt;
      if (r_state == S_WAIT && r_cnt == 4'd1 && !r_write) r_hrdata <= w_rd_data;
    end

  assign HREADYOUT = r_hreadyout;
  assign HRESP     = r_hresp;
  assign HRDATA    = r_hrdata;
endmodule

// File: tb/tb_ahb_subordinate_mem.sv
// tb_ahb_subordinate_mem: scoreboard bench for zero-wait and three-wait subordinate instances
module tb_ahb_subordinate_mem;
  logic        clk = 1'b0;
  logic        rst;
  logic        hsel0, hsel3;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [3:0]  hwstrb;
  logic        rdy0, rdy3, resp0, resp3;
  logic [31:0] rd0, rd3;
  logic [31:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  ahb_subordinate_mem #(.WAIT_STATES(0)) u0 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HWDATA(hwdata), .HWSTRB(hwstrb), .HREADY(rdy0),
    .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rd0));

  ahb_subordinate_mem #(.WAIT_STATES(3)) u3 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel3), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HWDATA(hwdata), .HWSTRB(hwstrb), .HREADY(rdy3),
    .HREADYOUT(rdy3), .HRESP(resp3), .HRDATA(rd3));

  task automatic do_xfer(input int d, input logic wr, input logic [31:0] a, input logic [2:0] sz,
                         input logic [31:0] wd, input logic [3:0] st, output int waits,
                         output logic resp_first, output logic resp, output logic [31:0] rdata);
    hsel0 = d == 0; hsel3 = d == 3;
    htrans = 2'b10; hwrite = wr; haddr = a; hsize = sz;
    @(posedge clk); #1;
    htrans = 2'b00; hwdata = wd; hwstrb = st;
    waits = 0;
    @(negedge clk);
    resp_first = d == 0 ? resp0 : resp3;
    while (!(d == 0 ? rdy0 : rdy3) && waits < 40) begin
      waits++;
      @(negedge clk);
    end
    resp  = d == 0 ? resp0 : resp3;
    rdata = d == 0 ? rd0 : rd3;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; hsel0 = 0; hsel3 = 0; htrans = 2'b00; hwrite = 0; haddr = 0; hsize = 3'b010;
    hwdata = 0; hwstrb = 0;
    repeat (2) @(negedge clk);
    n_tests++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL reset_ready0 got %b expected 1", rdy0); end
    n_tests++; if (resp0 !== 1'b0) begin n_fail++; $display("FAIL reset_resp0 got %b expected 0", resp0); end
    n_tests++; if (rd0 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata0 got %h expected 0", rd0); end
    n_tests++; if (rdy3 !== 1'b1) begin n_fail++; $display("FAIL reset_ready3 got %b expected 1", rdy3); end
    n_tests++; if (resp3 !== 1'b0) begin n_fail++; $display("FAIL reset_resp3 got %b expected 0", resp3); end
    n_tests++; if (rd3 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata3 got %h expected 0", rd3); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    hsel0 = 1; hsel3 = 0; htrans = 2'b10; hwrite = 1; haddr = 32'h10; hsize = 3'b010;
    @(posedge clk); #1;
    hwdata = 32'hDEADBEEF; hwstrb = 4'hF; hwrite = 0;
    exp_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    n_tests++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL b2b_wr_ready got %b expected 1", rdy0); end
    n_tests++; if (resp0 !== 1'b0) begin n_fail++; $display("FAIL b2b_wr_resp got %b expected 0", resp0); end
    @(posedge clk); #1;
    htrans = 2'b00; hwdata = 32'h0;
    @(negedge clk);
    exp = exp_q.pop_front();
    n_tests++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL b2b_rd_ready got %b expected 1", rdy0); end
    n_tests++; if (resp0 !== 1'b0) begin n_fail++; $display("FAIL b2b_rd_resp got %b expected 0", resp0); end
    n_tests++; if (rd0 !== exp) begin n_fail++; $display("FAIL b2b_fwd_data got %h expected %h", rd0, exp); end
    @(posedge clk); #1;
  endtask

  task automatic test_byte_strobe();
    int w; logic rf, r; logic [31:0] d, exp;
    do_xfer(0, 1, 32'h20, 3'b010, 32'h11223344, 4'hF, w, rf, r, d);
    do_xfer(0, 1, 32'h22, 3'b000, 32'h00AA0000, 4'hF, w, rf, r, d);
    exp_q.push_back(32'h11AA3344);
    do_xfer(0, 0, 32'h20, 3'b010, 32'h0, 4'h0, w, rf, r, d);
    exp = exp_q.pop_front();
    n_tests++; if (r !== 1'b0) begin n_fail++; $display("FAIL byte_rd_resp got %b expected 0", r); end
    n_tests++; if (d !== exp) begin n_fail++; $display("FAIL byte_merge got %h expected %h", d, exp); end
    do_xfer(0, 1, 32'h22, 3'b000, 32'h00550000, 4'h0, w, rf, r, d);
    exp_q.push_back(32'h11AA3344);
    do_xfer(0, 0, 32'h20, 3'b010, 32'h0, 4'h0, w, rf, r, d);
    exp = exp_q.pop_front();
    n_tests++; if (d !== exp) begin n_fail++; $display("FAIL byte_nostrobe got %h expected %h", d, exp); end
    n_tests++; if (w !== 0) begin n_fail++; $display("FAIL byte_zero_wait got %0d expected 0", w); end
  endtask

  task automatic test_idle_busy();
    int w; logic rf, r; logic [31:0] d, exp;
    for (int i = 0; i < 4; i++) begin
      hsel0 = i < 2; hsel3 = 0;
      htrans = i == 0 ? 2'b00 : i == 1 ? 2'b01 : 2'b10;
      hwrite = 1; haddr = 32'h20; hsize = 3'b010; hwdata = 32'hFFFFFFFF; hwstrb = 4'hF;
      @(negedge clk);
      n_tests++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL idle_ready[%0d] got %b expected 1", i, rdy0); end
      n_tests++; if (resp0 !== 1'b0) begin n_fail++; $display("FAIL idle_resp[%0d] got %b expected 0", i, resp0); end
      n_tests++; if (rd0 !== 32'h11AA3344) begin n_fail++; $display("FAIL idle_hold[%0d] got %h expected 11aa3344", i, rd0); end
      @(posedge clk); #1;
    end
    exp_q.push_back(32'h11AA3344);
    do_xfer(0, 0, 32'h20, 3'b010, 32'h0, 4'h0, w, rf, r, d);
    exp = exp_q.pop_front();
    n_tests++; if (d !== exp) begin n_fail++; $display("FAIL idle_nochange got %h expected %h", d, exp); end
  endtask

  task automatic test_wait_states();
    int w; logic rf, r; logic [31:0] d, exp;
    do_xfer(3, 1, 32'h40, 3'b010, 32'hA5A55A5A, 4'hF, w, rf, r, d);
    n_tests++; if (w !== 3) begin n_fail++; $display("FAIL ws_wr_waits got %0d expected 3", w); end
    exp_q.push_back(32'hA5A55A5A);
    do_xfer(3, 0, 32'h40, 3'b010, 32'h0, 4'h0, w, rf, r, d);
    exp = exp_q.pop_front();
    n_tests++; if (w !== 3) begin n_fail++; $display("FAIL ws_rd_waits got %0d expected 3", w); end
    n_tests++; if (rf !== 1'b0) begin n_fail++; $display("FAIL ws_wait_resp got %b expected 0", rf); end
    n_tests++; if (r !== 1'b0) begin n_fail++; $display("FAIL ws_rd_resp got %b expected 0", r); end
    n_tests++; if (d !== exp) begin n_fail++; $display("FAIL ws_rd_data got %h expected %h", d, exp); end
  endtask

  task automatic test_errors();
    int w; logic rf, r; logic [31:0] d, exp;
    do_xfer(0, 1, 32'h0, 3'b010, 32'h0BADF00D, 4'hF, w, rf, r, d);
    exp_q.push_back(32'h0BADF00D);
    do_xfer(0, 0, 32'h0, 3'b010, 32'h0, 4'h0, w, rf, r, d);
    exp = exp_q.pop_front();
    n_tests++; if (d !== exp) begin n_fail++; $display("FAIL err_setup got %h expected %h", d, exp); end
    for (int i = 0; i < 3; i++) begin
      do_xfer(0, i == 2, i == 1 ? 32'h01 : 32'h400, i == 1 ? 3'b001 : 3'b010, 32'hFFFFFFFF, 4'hF,
              w, rf, r, d);
      n_tests++; if (w !== 1) begin n_fail++; $display("FAIL err_waits[%0d] got %0d expected 1", i, w); end
      n_tests++; if (rf !== 1'b1) begin n_fail++; $display("FAIL err_resp1[%0d] got %b expected 1", i, rf); end
      n_tests++; if (r !== 1'b1) begin n_fail++; $display("FAIL err_resp2[%0d] got %b expected 1", i, r); end
      n_tests++; if (d !== 32'h0BADF00D) begin n_fail++; $display("FAIL err_hold[%0d] got %h expected 0badf00d", i, d); end
    end
    exp_q.push_back(32'h0BADF00D);
    do_xfer(0, 0, 32'h0, 3'b010, 32'h0, 4'h0, w, rf, r, d);
    exp = exp_q.pop_front();
    n_tests++; if (r !== 1'b0) begin n_fail++; $display("FAIL err_after_resp got %b expected 0", r); end
    n_tests++; if (d !== exp) begin n_fail++; $display("FAIL err_mem_untouched got %h expected %h", d, exp); end
  endtask

  task automatic test_reset_mid();
    int w; logic rf, r; logic [31:0] d, exp;
    do_xfer(3, 1, 32'h30, 3'b010, 32'hCAFEF00D, 4'hF, w, rf, r, d);
    hsel0 = 0; hsel3 = 1; htrans = 2'b10; hwrite = 1; haddr = 32'h30; hsize = 3'b010;
    @(posedge clk); #1;
    htrans = 2'b00; hwdata = 32'h12345678; hwstrb = 4'hF;
    @(negedge clk);
    n_tests++; if (rdy3 !== 1'b0) begin n_fail++; $display("FAIL rst_in_wait got %b expected 0", rdy3); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (rdy3 !== 1'b1) begin n_fail++; $display("FAIL rst_async_ready got %b expected 1", rdy3); end
    n_tests++; if (resp3 !== 1'b0) begin n_fail++; $display("FAIL rst_async_resp got %b expected 0", resp3); end
    n_tests++; if (rd3 !== 32'h0) begin n_fail++; $display("FAIL rst_async_rdata got %h expected 0", rd3); end
    hsel3 = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(32'hCAFEF00D);
    do_xfer(3, 0, 32'h30, 3'b010, 32'h0, 4'h0, w, rf, r, d);
    exp = exp_q.pop_front();
    n_tests++; if (d !== exp) begin n_fail++; $display("FAIL rst_write_discarded got %h expected %h", d, exp); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_byte_strobe();
    test_idle_busy();
    test_wait_states();
    test_errors();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
